sync_ser_tx: RTL



---
 rtl/sync_ser_tx_pkg.sv | 8 +
 rtl/sync_ser_shift.sv | 19 +
 rtl/sync_ser_tx.sv | 88 ++++++++
 3 files changed

// File: rtl/sync_ser_tx_pkg.sv
// sync_ser_tx_pkg: shared state encoding, start marker and counter sizing for the link transmitter
package sync_ser_tx_pkg;
  typedef enum logic [2:0] {IDLE, LOADED, START, DATA, STOP} state_t;
  localparam logic START_MARK = 1'b1;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sync_ser_shift.sv
// sync_ser_shift: parallel-load shift register presenting the next serial bit on so
module sync_ser_shift #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             so
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else if (load) sr <= d;
    else if (shift) sr <= LSB_FIRST ? sr >> 1 : sr << 1;
  assign so = LSB_FIRST ? sr[0] : sr[WIDTH-1];
endmodule

// File: rtl/sync_ser_tx.sv
// sync_ser_tx: serialises a host word onto the sd/sld load link, one step per tick
module sync_ser_tx
  import sync_ser_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1,
  parameter int GAP = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             sd,
  output logic             sld,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH);
  state_t state;
  logic [CW-1:0] bitcnt;
  logic [3:0] gapcnt;
  logic so, accept, more, shift;
  assign accept = din_vld & din_rdy;
  assign more = bitcnt < W_LAST;
  // the shifter advances on every tick that emits a data bit, so so always holds the next one
  assign shift = tick & (state == START | (state == DATA & more));
  sync_ser_shift #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_shift (
    .clk(sys_clk),
    .rst(reset),
    .load(accept),
    .shift(shift),
    .d(din),
    .so(so)
  );
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      sd <= 1'b0;
      sld <= 1'b0;
      busy <= 1'b0;
      din_rdy <= 1'b1;
      bitcnt <= '0;
      gapcnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= LOADED;
          din_rdy <= 1'b0;
          busy <= 1'b1;
        end
        LOADED: if (tick) begin
          sd <= START_MARK;
          sld <= 1'b1;
          state <= START;
        end
        START: if (tick) begin
          sd <= so;
          bitcnt <= CW'(1);
          state <= DATA;
        end
        DATA: if (tick) begin
          if (more) begin
            sd <= so;
            bitcnt <= bitcnt + 1'b1;
          end else begin
            sd <= 1'b0;
            sld <= 1'b0;
            gapcnt <= 4'(GAP - 1);
            state <= STOP;
          end
        end
        STOP: if (tick) begin
          if (gapcnt != '0) gapcnt <= gapcnt - 4'd1;
          else begin
            state <= IDLE;
            din_rdy <= 1'b1;
            busy <= 1'b0;
            bitcnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assert property (@(posedge sys_clk) GAP inside {[1:15]} && WIDTH inside {[1:32]});
endmodule
